// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator
//
// Collects COUNT unsigned sum samples from the upstream adder stage into one
// window total. When the window is complete, it presents the total, a
// truncated average and the sample count on a valid/ready output. It then
// holds that result until the downstream side takes it. Input is
// back-pressured (in_ready=0) while a result is pending, so no sample is
// lost.
//
// Parameters
//   DATA_W  width of each incoming sample
//   COUNT   samples per window (power of two, 2..64)
//   ACC_W   accumulator width, at least DATA_W + log2(COUNT)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; overrides every other input
//   in_data    sample from the upstream adder
//   in_valid   in_data is valid this cycle
//   in_ready   block accepts a sample this cycle
//   out_sum    window total (registered)
//   out_avg    out_sum >> log2(COUNT), truncated (combinational from out_sum)
//   out_cnt    number of samples contained in out_sum
//   out_valid  out_sum/out_avg/out_cnt are valid
//   out_ready  downstream consumes the result this cycle
//   flush      (only with SUM_ACC_FLUSH_EN) emit a partial window early
//
// Build option
//   SUM_ACC_FLUSH_EN  adds the flush input. When it is undefined, every
//                     window holds exactly COUNT samples.
// ---------------------------------------------------------------------------
module sum_accumulator #(
    parameter int DATA_W = 8,
    parameter int COUNT  = 4,
    parameter int ACC_W  = DATA_W + $clog2(COUNT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [ACC_W-1:0]         out_sum,
    output logic [DATA_W-1:0]        out_avg,
    output logic [$clog2(COUNT):0]   out_cnt,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef SUM_ACC_FLUSH_EN
    ,
    input  logic                     flush
`endif
);

    localparam int LOG2  = $clog2(COUNT);
    localparam int CNT_W = LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    // Reject parameter sets for which the width guarantee cannot hold.
    if (COUNT < 2 || COUNT > 64 || (COUNT & (COUNT - 1)) != 0) begin : g_bad_count
        $error("sum_accumulator: COUNT must be a power of two in 2..64");
    end
    if (ACC_W < DATA_W + LOG2) begin : g_bad_acc_w
        $error("sum_accumulator: ACC_W must be at least DATA_W + log2(COUNT)");
    end

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Samples are zero-extended before they are added. COUNT * (2^DATA_W - 1)
    // always fits in ACC_W, so the accumulator cannot wrap.
    function automatic logic [ACC_W-1:0] zext(input logic [DATA_W-1:0] d);
        return {{(ACC_W - DATA_W){1'b0}}, d};
    endfunction

    // The average uses a fixed shift even for a flushed partial window.
    function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] s);
        return DATA_W'(s >> LOG2);
    endfunction

    state_t             state_p0;
    logic               rdy_p0;
    logic [ACC_W-1:0]   acc_p0;
    logic [CNT_W-1:0]   cnt_p0;

    logic [ACC_W-1:0]   sum_p1;
    logic [CNT_W-1:0]   cnt_p1;
    logic               vld_p1;

    logic               take;
    logic               window_full;
    logic               flush_take;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt_next;

    // ---- stage p0: accept / accumulate ------------------------------------
    always_comb begin
        take        = in_valid && (state_p0 == ACCUM) && !rst;
        acc_next    = acc_p0 + (take ? zext(in_data) : '0);
        cnt_next    = cnt_p0 + {{(CNT_W - 1){1'b0}}, take};
        window_full = take && (cnt_p0 == CNT_LAST);
        flush_take  = 1'b0;
`ifdef SUM_ACC_FLUSH_EN
        // An empty window is never flushed. A sample accepted on the same
        // cycle as the flush is included in the result.
        flush_take  = flush && (state_p0 == ACCUM) && ((cnt_p0 != '0) || take);
`endif
    end

    // ---- stage p1: result register and handshake FSM ----------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= ACCUM;
            rdy_p0   <= 1'b1;
            vld_p1   <= 1'b0;
            acc_p0   <= '0;
            cnt_p0   <= '0;
            sum_p1   <= '0;
            cnt_p1   <= '0;
        end else begin
            case (state_p0)
                ACCUM: begin
                    acc_p0 <= acc_next;
                    cnt_p0 <= cnt_next;
                    if (window_full || flush_take) begin
                        sum_p1   <= acc_next;
                        cnt_p1   <= cnt_next;
                        vld_p1   <= 1'b1;
                        rdy_p0   <= 1'b0;
                        state_p0 <= HOLD;
                    end
                end
                HOLD: begin
                    // Result stays frozen until it is consumed.
                    if (out_ready) begin
                        acc_p0   <= '0;
                        cnt_p0   <= '0;
                        vld_p1   <= 1'b0;
                        rdy_p0   <= 1'b1;
                        state_p0 <= ACCUM;
                    end
                end
                default: begin
                    state_p0 <= ACCUM;
                    rdy_p0   <= 1'b1;
                    vld_p1   <= 1'b0;
                end
            endcase
        end
    end

    // in_ready is high while reset is held. Nothing is accumulated then,
    // because take is gated by rst.
    assign in_ready  = rdy_p0 | rst;
    assign out_valid = vld_p1;
    assign out_sum   = sum_p1;
    assign out_cnt   = cnt_p1;
    assign out_avg   = avg_trunc(sum_p1);

endmodule

// File: tb/tb_sum_accumulator.sv
module tb_sum_accumulator;

    localparam int DATA_W = 8;
    localparam int COUNT  = 4;
    localparam int ACC_W  = 10;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [DATA_W-1:0] out_avg;
    logic [2:0]        out_cnt;
    logic              out_valid;
    logic              out_ready;
`ifdef SUM_ACC_FLUSH_EN
    logic              flush;
`endif

    int checks = 0;
    int errors = 0;

    sum_accumulator #(
        .DATA_W(DATA_W),
        .COUNT (COUNT),
        .ACC_W (ACC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_sum  (out_sum),
        .out_avg  (out_avg),
        .out_cnt  (out_cnt),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef SUM_ACC_FLUSH_EN
        ,
        .flush    (flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef SUM_ACC_FLUSH_EN
        flush     = 1'b0;
`endif
        tick();
        tick();
        // Reset is still held while a sample is offered: not accumulated.
        in_valid = 1'b1;
        in_data  = 8'd99;
        #1;
        chk("rst_in_ready", in_ready, 1);
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_avg", out_avg, 0);
        chk("rst_out_cnt", out_cnt, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Window 10,20,30,40
        send(8'd10);
        chk("w1_no_valid_1", out_valid, 0);
        send(8'd20);
        send(8'd30);
        chk("w1_no_valid_3", out_valid, 0);
        send(8'd40);
        in_valid = 1'b0;
        chk("w1_valid", out_valid, 1);
        chk("w1_sum", out_sum, 100);
        chk("w1_avg", out_avg, 25);
        chk("w1_cnt", out_cnt, 4);
        chk("w1_in_ready_low", in_ready, 0);
        tick();
        chk("w1_ret_in_ready", in_ready, 1);
        chk("w1_ret_valid", out_valid, 0);

        // Max samples with downstream stalled for 5 cycles; input ignored in HOLD
        out_ready = 1'b0;
        send(8'd255);
        send(8'd255);
        send(8'd255);
        send(8'd255);
        in_data = 8'd77;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", out_sum, 1020);
            chk("hold_avg", out_avg, 255);
            chk("hold_cnt", out_cnt, 4);
            chk("hold_in_ready", in_ready, 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("hold_still_valid", out_valid, 1);
        tick();
        chk("hold_hs_in_ready", in_ready, 1);
        chk("hold_hs_valid", out_valid, 0);

        // Back-to-back windows 1..8 with a sample held through the HOLD cycle
        send(8'd1);
        send(8'd2);
        send(8'd3);
        send(8'd4);
        chk("b2b_w1_valid", out_valid, 1);
        chk("b2b_w1_sum", out_sum, 10);
        chk("b2b_gap_in_ready", in_ready, 0);
        send(8'd5);
        chk("b2b_gap_over", in_ready, 1);
        chk("b2b_gap_valid", out_valid, 0);
        send(8'd5);
        chk("b2b_accept5_ready", in_ready, 1);
        send(8'd6);
        send(8'd7);
        chk("b2b_no_early", out_valid, 0);
        send(8'd8);
        in_valid = 1'b0;
        chk("b2b_w2_valid", out_valid, 1);
        chk("b2b_w2_sum", out_sum, 26);
        chk("b2b_w2_cnt", out_cnt, 4);
        tick();
        chk("b2b_end_ready", in_ready, 1);

        // Reset mid-window discards the partial sum
        send(8'd5);
        send(8'd5);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", out_valid, 0);
        send(8'd1);
        send(8'd1);
        chk("midrst_no_out_2", out_valid, 0);
        send(8'd1);
        chk("midrst_no_out_3", out_valid, 0);
        send(8'd1);
        in_valid = 1'b0;
        chk("midrst_valid_4", out_valid, 1);
        chk("midrst_sum", out_sum, 4);
        chk("midrst_cnt", out_cnt, 4);
        tick();

        // Reset while a result is pending drops it
        out_ready = 1'b0;
        send(8'd2);
        send(8'd2);
        send(8'd2);
        send(8'd2);
        in_valid = 1'b0;
        chk("holdrst_pre_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        chk("holdrst_valid", out_valid, 0);
        chk("holdrst_sum", out_sum, 0);
        chk("holdrst_in_ready", in_ready, 1);

`ifdef SUM_ACC_FLUSH_EN
        // Flush with an empty window is ignored
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_empty_ignored", out_valid, 0);
        // 7,9 then flush
        send(8'd7);
        send(8'd9);
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_a_valid", out_valid, 1);
        chk("fl_a_sum", out_sum, 16);
        chk("fl_a_cnt", out_cnt, 2);
        chk("fl_a_avg", out_avg, 4);
        tick();
        // 7 then flush together with sample 3
        send(8'd7);
        flush = 1'b1;
        send(8'd3);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_b_valid", out_valid, 1);
        chk("fl_b_sum", out_sum, 10);
        chk("fl_b_cnt", out_cnt, 2);
        chk("fl_b_avg", out_avg, 2);
        tick();
        chk("fl_b_ret_ready", in_ready, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
